// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-buffer fields in, pipeline register/PC controls out; master is the hazard controller.
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  logic                  idex_MemRead;
  logic [REG_ADDR_W-1:0] idex_rd;
  logic [REG_ADDR_W-1:0] ifid_rs1;
  logic [REG_ADDR_W-1:0] ifid_rs2;
  logic                  ifid_uses_rs2;
  logic                  exmem_branch;
  logic                  exmem_zero;
  logic                  exmem_MemRead;
  logic                  exmem_MemWrite;
  logic                  dmem_ready;

  logic                  pc_write;
  logic                  pc_src;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  exmem_flush;
  logic                  pipe_hold;
  logic                  mem_err;

  modport master (
    input  idex_MemRead, idex_rd, ifid_rs1, ifid_rs2, ifid_uses_rs2,
           exmem_branch, exmem_zero, exmem_MemRead, exmem_MemWrite, dmem_ready,
    output pc_write, pc_src, ifid_write, ifid_flush, idex_flush, exmem_flush,
           pipe_hold, mem_err
  );

  modport slave (
    output idex_MemRead, idex_rd, ifid_rs1, ifid_rs2, ifid_uses_rs2,
           exmem_branch, exmem_zero, exmem_MemRead, exmem_MemWrite, dmem_ready,
    input  pc_write, pc_src, ifid_write, ifid_flush, idex_flush, exmem_flush,
           pipe_hold, mem_err
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use compare: a load in ID/EX writing a register the IF/ID instruction reads.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  uses_rs2,
  output logic                  hazard
);

  // x0 is hardwired to zero, so a load targeting it can never feed a consumer
  assign hazard = mem_read && (rd != X0) &&
                  ((rd == rs1) || (uses_rs2 && (rd == rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use bubbles, taken-branch flushes, memory-wait holds with timeout.
// Outputs are combinational from state and inputs; HAZ_PERF_CNT_EN adds stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_hazard_ctrl_if.master   hif
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_events
`endif
);

  state_t            state;
  state_t            state_nx;
  state_t            state_eff;
  logic [TO_W-1:0]   wcnt;
  logic [TO_W-1:0]   wcnt_nx;
  logic              mem_err_q;
  logic              set_err;
  logic              mem_op;
  logic              taken;
  logic              lu;
  logic              timed_out;
  logic              hold;

  hazard_detect u_hazard_detect (
    .mem_read (hif.idex_MemRead),
    .rd       (hif.idex_rd),
    .rs1      (hif.ifid_rs1),
    .rs2      (hif.ifid_rs2),
    .uses_rs2 (hif.ifid_uses_rs2),
    .hazard   (lu)
  );

  assign mem_op    = hif.exmem_MemRead | hif.exmem_MemWrite;
  assign taken     = hif.exmem_branch & hif.exmem_zero;
  assign timed_out = (wcnt == TO_W'(MEM_TIMEOUT));

  // While reset is asserted the outputs follow the RUN rules regardless of the stale state
  assign state_eff = reset ? ST_RUN : state;
  assign hold      = (state_eff == ST_RUN) ? (mem_op & ~hif.dmem_ready)
                                           : (~hif.dmem_ready & ~timed_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      wcnt      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (set_err) mem_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    set_err  = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_op && !hif.dmem_ready) begin
          state_nx = ST_MEM_WAIT;
          wcnt_nx  = TO_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (hif.dmem_ready) begin
          state_nx = ST_RUN;
          wcnt_nx  = '0;
        end else if (timed_out) begin
          state_nx = ST_RUN;
          wcnt_nx  = '0;
          set_err  = 1'b1;
        end else begin
          wcnt_nx  = wcnt + TO_W'(1);
        end
      end
      default: begin
        state_nx = ST_RUN;
        wcnt_nx  = '0;
      end
    endcase
  end

  always_comb begin
    hif.pc_write    = 1'b1;
    hif.pc_src      = 1'b0;
    hif.ifid_write  = 1'b1;
    hif.ifid_flush  = 1'b0;
    hif.idex_flush  = 1'b0;
    hif.exmem_flush = 1'b0;
    hif.pipe_hold   = 1'b0;
    if (hold) begin
      hif.pc_write   = 1'b0;
      hif.ifid_write = 1'b0;
      hif.pipe_hold  = 1'b1;
    end else if (taken) begin
      hif.pc_src      = 1'b1;
      hif.ifid_flush  = 1'b1;
      hif.idex_flush  = 1'b1;
      hif.exmem_flush = 1'b1;
    end else if (lu) begin
      hif.pc_write   = 1'b0;
      hif.ifid_write = 1'b0;
      hif.idex_flush = 1'b1;
    end
  end

  assign hif.mem_err = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!hif.pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (hif.ifid_flush && (flush_events != '1)) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int TO = 15;
  // {pc_write, pc_src, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold, mem_err}
  localparam logic [7:0] O_RUN   = 8'b1010_0000;
  localparam logic [7:0] O_HOLD  = 8'b0000_0010;
  localparam logic [7:0] O_LU    = 8'b0000_1000;
  localparam logic [7:0] O_TAKEN = 8'b1111_1100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hif();
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .TO_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Model: are we inside a memory wait, how many hold cycles so far, sticky error, event totals
  bit     m_wait;
  int     m_waited;
  bit     m_err;
  longint m_stalls;
  longint m_flushes;

  function automatic logic [7:0] dut_out();
    return {hif.pc_write, hif.pc_src, hif.ifid_write, hif.ifid_flush,
            hif.idex_flush, hif.exmem_flush, hif.pipe_hold, hif.mem_err};
  endfunction

  function automatic logic [7:0] model_out();
    bit mem_op, taken, lu, holding;
    mem_op = hif.exmem_MemRead || hif.exmem_MemWrite;
    taken  = hif.exmem_branch && hif.exmem_zero;
    lu     = hif.idex_MemRead && (hif.idex_rd != 0) &&
             ((hif.idex_rd == hif.ifid_rs1) || (hif.ifid_uses_rs2 && (hif.idex_rd == hif.ifid_rs2)));
    if (reset || !m_wait) holding = mem_op && !hif.dmem_ready;
    else                  holding = !hif.dmem_ready && (m_waited < TO);
    if (holding)   return O_HOLD  | {7'd0, m_err};
    else if (taken) return O_TAKEN | {7'd0, m_err};
    else if (lu)    return O_LU    | {7'd0, m_err};
    else            return O_RUN   | {7'd0, m_err};
  endfunction

  task automatic model_step();
    logic [7:0] e;
    e = model_out();
    if (reset) begin
      m_wait = 0; m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!e[7]) m_stalls++;
      if (e[4])  m_flushes++;
      if (!m_wait) begin
        if (e[1]) begin m_wait = 1; m_waited = 1; end
      end else if (hif.dmem_ready) begin
        m_wait = 0;
      end else if (m_waited >= TO) begin
        m_err = 1; m_wait = 0;
      end else begin
        m_waited++;
      end
    end
  endtask

  // Advance one clock; the model sees the same pre-edge inputs as the DUT
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_idle();
    hif.idex_MemRead = 0; hif.idex_rd = 0; hif.ifid_rs1 = 0; hif.ifid_rs2 = 0;
    hif.ifid_uses_rs2 = 0; hif.exmem_branch = 0; hif.exmem_zero = 0;
    hif.exmem_MemRead = 0; hif.exmem_MemWrite = 0; hif.dmem_ready = 1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    set_idle();
    reset = 1;
    tick();
    got = dut_out(); tests++;
    if (got !== O_RUN) begin fails++; $display("FAIL reset_during got=%b exp=%b", got, O_RUN); end
    reset = 0;
    tick();
    got = dut_out(); tests++;
    if (got !== O_RUN) begin fails++; $display("FAIL reset_after got=%b exp=%b", got, O_RUN); end
  endtask

  task automatic test_load_use();
    logic [7:0] got;
    set_idle();
    hif.idex_MemRead = 1; hif.idex_rd = 5; hif.ifid_rs1 = 5; #1;
    got = dut_out(); tests++;
    if (got !== O_LU) begin fails++; $display("FAIL load_use_stall got=%b exp=%b", got, O_LU); end
    tick();
    hif.idex_MemRead = 0; hif.idex_rd = 0; #1;
    got = dut_out(); tests++;
    if (got !== O_RUN) begin fails++; $display("FAIL load_use_bubble got=%b exp=%b", got, O_RUN); end
    tick();
  endtask

  task automatic test_x0_rs2();
    logic [7:0] got;
    set_idle();
    hif.idex_MemRead = 1; hif.idex_rd = 0; hif.ifid_rs1 = 0; #1;
    got = dut_out(); tests++;
    if (got !== O_RUN) begin fails++; $display("FAIL rd_x0 got=%b exp=%b", got, O_RUN); end
    tick();
    hif.idex_rd = 7; hif.ifid_rs1 = 3; hif.ifid_rs2 = 7; hif.ifid_uses_rs2 = 0; #1;
    got = dut_out(); tests++;
    if (got !== O_RUN) begin fails++; $display("FAIL rs2_unused got=%b exp=%b", got, O_RUN); end
    hif.ifid_uses_rs2 = 1; #1;
    got = dut_out(); tests++;
    if (got !== O_LU) begin fails++; $display("FAIL rs2_used got=%b exp=%b", got, O_LU); end
    tick();
    set_idle(); #1;
  endtask

  task automatic test_branch_lu();
    logic [7:0] got;
    set_idle();
    hif.idex_MemRead = 1; hif.idex_rd = 9; hif.ifid_rs1 = 9;
    hif.exmem_branch = 1; hif.exmem_zero = 1; #1;
    got = dut_out(); tests++;
    if (got !== O_TAKEN) begin fails++; $display("FAIL taken_over_lu got=%b exp=%b", got, O_TAKEN); end
    hif.exmem_zero = 0; #1;
    got = dut_out(); tests++;
    if (got !== O_LU) begin fails++; $display("FAIL not_taken_lu got=%b exp=%b", got, O_LU); end
    tick();
    set_idle(); #1;
  endtask

  task automatic test_mem_wait();
    logic [7:0] got;
    set_idle();
    hif.exmem_MemRead = 1; hif.dmem_ready = 0;
    hif.exmem_branch = 1; hif.exmem_zero = 1;  // malformed: memory wait must win
    for (int i = 0; i < 3; i++) begin
      #1;
      got = dut_out(); tests++;
      if (got !== O_HOLD) begin fails++; $display("FAIL mem_hold[%0d] got=%b exp=%b", i, got, O_HOLD); end
      tick();
    end
    hif.dmem_ready = 1; #1;
    got = dut_out(); tests++;
    if (got !== O_TAKEN) begin fails++; $display("FAIL mem_release got=%b exp=%b", got, O_TAKEN); end
    tick();
    set_idle(); #1;
    got = dut_out(); tests++;
    if (got !== O_RUN) begin fails++; $display("FAIL mem_after got=%b exp=%b", got, O_RUN); end
  endtask

  task automatic test_timeout_reset();
    logic [7:0] got;
    int holds;
    set_idle();
    hif.exmem_MemWrite = 1; hif.dmem_ready = 0;
    holds = 0;
    for (int i = 0; i < TO; i++) begin
      #1;
      if (dut_out() === O_HOLD) holds++;
      tick();
    end
    tests++;
    if (holds != TO) begin fails++; $display("FAIL timeout_holds got=%0d exp=%0d", holds, TO); end
    got = dut_out(); tests++;
    if (got !== O_RUN) begin fails++; $display("FAIL timeout_release got=%b exp=%b", got, O_RUN); end
    tick();
    got = dut_out(); tests++;
    if (got !== (O_HOLD | 8'd1)) begin fails++; $display("FAIL timeout_err_rewait got=%b exp=%b", got, O_HOLD | 8'd1); end
    tick(); tick();
    reset = 1; #1;
    got = dut_out(); tests++;
    if (got !== (O_HOLD | 8'd1)) begin fails++; $display("FAIL reset_midwait got=%b exp=%b", got, O_HOLD | 8'd1); end
    tick();
    reset = 0;
    hif.exmem_MemWrite = 0; #1;
    got = dut_out(); tests++;
    if (got !== O_RUN) begin fails++; $display("FAIL reset_to_run got=%b exp=%b", got, O_RUN); end
    tick();
    set_idle(); #1;
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    int bad;
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      hif.idex_MemRead   = $urandom_range(0, 1);
      hif.idex_rd        = 5'($urandom_range(0, 3));
      hif.ifid_rs1       = 5'($urandom_range(0, 3));
      hif.ifid_rs2       = 5'($urandom_range(0, 3));
      hif.ifid_uses_rs2  = $urandom_range(0, 1);
      hif.exmem_branch   = $urandom_range(0, 1);
      hif.exmem_zero     = $urandom_range(0, 1);
      hif.exmem_MemRead  = ($urandom_range(0, 3) == 0);
      hif.exmem_MemWrite = ($urandom_range(0, 5) == 0);
      // every third block of 60 cycles memory is mostly stalled to reach the timeout
      if ((c / 60) % 3 == 2) hif.dmem_ready = ($urandom_range(0, 19) == 0);
      else                   hif.dmem_ready = ($urandom_range(0, 2) != 0);
      #1;
      got = dut_out(); exp = model_out(); tests++;
      if (got !== exp) begin
        fails++;
        if (bad < 10) $display("FAIL random_cycle[%0d] got=%b exp=%b", c, got, exp);
        bad++;
      end
`ifdef HAZ_PERF_CNT_EN
      tests++;
      if (stall_cycles !== 32'(m_stalls) || flush_events !== 32'(m_flushes)) begin
        fails++;
        if (bad < 10) $display("FAIL random_perf[%0d] got=%0d/%0d exp=%0d/%0d",
                               c, stall_cycles, flush_events, m_stalls, m_flushes);
        bad++;
      end
`endif
      tick();
    end
    reset = 0;
    set_idle();
    tick();
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf();
    set_idle();
    reset = 1; tick(); reset = 0;
    hif.idex_MemRead = 1; hif.idex_rd = 5; hif.ifid_rs1 = 5; tick();
    set_idle();
    hif.idex_MemRead = 1; hif.idex_rd = 6; hif.ifid_rs1 = 6;
    hif.exmem_branch = 1; hif.exmem_zero = 1; tick();
    set_idle();
    hif.exmem_MemRead = 1; hif.dmem_ready = 0;
    tick(); tick(); tick();
    hif.dmem_ready = 1; tick();
    set_idle(); #1;
    tests++;
    if (stall_cycles !== 32'd4) begin fails++; $display("FAIL perf_stalls got=%0d exp=4", stall_cycles); end
    tests++;
    if (flush_events !== 32'd1) begin fails++; $display("FAIL perf_flushes got=%0d exp=1", flush_events); end
  endtask
`endif

  initial begin
    reset = 1;
    set_idle();
    m_wait = 0; m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    @(negedge clk); #1;
    test_reset();
    test_load_use();
    test_x0_rs2();
    test_branch_lu();
    test_mem_wait();
    test_timeout_reset();
    test_random();
`ifdef HAZ_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
